// File: rtl/canvas_write_arbiter_if.sv
// Write-side bus of the canvas arbiter: the I2C request holding-register handshake
// and the single valid/ready pixel-write port toward the framebuffer.
interface canvas_write_arbiter_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic          i2c_valid;
  logic [XW-1:0] i2c_x;
  logic [YW-1:0] i2c_y;
  logic [2:0]    i2c_rgb;
  logic          i2c_clear;
  logic          i2c_ready;

  logic          wr_valid;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [2:0]    wr_rgb;
  logic          wr_ready;

  modport master (
    input  i2c_valid, i2c_x, i2c_y, i2c_rgb, i2c_clear,
    output i2c_ready,
    output wr_valid, wr_x, wr_y, wr_rgb,
    input  wr_ready
  );

  modport slave (
    output i2c_valid, i2c_x, i2c_y, i2c_rgb, i2c_clear,
    input  i2c_ready,
    input  wr_valid, wr_x, wr_y, wr_rgb,
    output wr_ready
  );
endinterface

// File: rtl/canvas_write_arbiter.sv
// Round-robin arbiter of button paints and I2C pixel writes onto one framebuffer write port.
// Define CANVAS_CLEAR_EN to compile in the whole-canvas clear sweep driven by i2c_clear.
module canvas_write_arbiter #(
  parameter int W  = 16,
  parameter int H  = 16,
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            btn,
  canvas_write_arbiter_if.master bus,
  output logic [XW-1:0]         cur_x,
  output logic [YW-1:0]         cur_y,
  output logic                  busy
);
  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

`ifdef CANVAS_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, WRITE} state_t;
`endif
  state_t state;

  logic [7:0]    btn_meta, btn_sync;
  logic [4:0]    btn_prev, btn_ev;
  logic          btn_pend, i2c_pend;
  logic [XW-1:0] btn_x, i2c_x_q;
  logic [YW-1:0] btn_y, i2c_y_q;
  logic [2:0]    btn_rgb, i2c_rgb_q;
  logic          last_i2c, grant_i2c;
  logic          accept, i2c_take, paint_take;
  logic          btn_done, i2c_done, clear_done;

  // Synchronizer and rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync[4:0];
    end
  end

  assign btn_ev     = btn_sync[4:0] & ~btn_prev;
  assign accept     = bus.wr_valid && bus.wr_ready;
  assign i2c_take   = bus.i2c_valid && bus.i2c_ready;
  assign paint_take = btn_ev[4] && !btn_pend;
  assign bus.i2c_ready = !i2c_pend && !rst;
  assign busy       = (state != IDLE);

  // Cursor: opposing presses in the same cycle cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      if (btn_ev[0] && !btn_ev[1])
        cur_y <= (cur_y == '0) ? Y_MAX : cur_y - YW'(1);
      else if (btn_ev[1] && !btn_ev[0])
        cur_y <= (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
      if (btn_ev[2] && !btn_ev[3])
        cur_x <= (cur_x == '0) ? X_MAX : cur_x - XW'(1);
      else if (btn_ev[3] && !btn_ev[2])
        cur_x <= (cur_x == X_MAX) ? '0 : cur_x + XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_pend <= 1'b0;
      i2c_pend <= 1'b0;
    end else begin
      if (btn_done)
        btn_pend <= 1'b0;
      else if (paint_take)
        btn_pend <= 1'b1;
      if (i2c_done)
        i2c_pend <= 1'b0;
      else if (i2c_take)
        i2c_pend <= 1'b1;
    end
  end

  // Payload registers capture the pre-move cursor; only the pend flags need reset
  always_ff @(posedge clk) begin
    if (paint_take) begin
      btn_x   <= cur_x;
      btn_y   <= cur_y;
      btn_rgb <= btn_sync[7:5];
    end
    if (i2c_take) begin
      i2c_x_q   <= bus.i2c_x;
      i2c_y_q   <= bus.i2c_y;
      i2c_rgb_q <= bus.i2c_rgb;
    end
  end

`ifdef CANVAS_CLEAR_EN
  logic i2c_clr_q;
  always_ff @(posedge clk) begin
    if (i2c_take)
      i2c_clr_q <= bus.i2c_clear;
  end
  assign clear_done = (state == CLEAR) && accept && (bus.wr_x == X_MAX) && (bus.wr_y == Y_MAX);
`else
  logic unused_clear;
  assign unused_clear = bus.i2c_clear;
  assign clear_done   = 1'b0;
`endif

  assign btn_done = (state == WRITE) && accept && !grant_i2c;
  assign i2c_done = ((state == WRITE) && accept && grant_i2c) || clear_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.wr_valid <= 1'b0;
      bus.wr_x     <= '0;
      bus.wr_y     <= '0;
      bus.wr_rgb   <= '0;
      last_i2c     <= 1'b1;
      grant_i2c    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef CANVAS_CLEAR_EN
          if (i2c_pend && i2c_clr_q) begin
            state        <= CLEAR;
            bus.wr_valid <= 1'b1;
            bus.wr_x     <= '0;
            bus.wr_y     <= '0;
            bus.wr_rgb   <= i2c_rgb_q;
            grant_i2c    <= 1'b1;
          end else
`endif
          if (btn_pend && (!i2c_pend || last_i2c)) begin
            state        <= WRITE;
            bus.wr_valid <= 1'b1;
            bus.wr_x     <= btn_x;
            bus.wr_y     <= btn_y;
            bus.wr_rgb   <= btn_rgb;
            grant_i2c    <= 1'b0;
          end else if (i2c_pend) begin
            state        <= WRITE;
            bus.wr_valid <= 1'b1;
            bus.wr_x     <= i2c_x_q;
            bus.wr_y     <= i2c_y_q;
            bus.wr_rgb   <= i2c_rgb_q;
            grant_i2c    <= 1'b1;
          end
        end
        WRITE: begin
          if (accept) begin
            state        <= IDLE;
            bus.wr_valid <= 1'b0;
            last_i2c     <= grant_i2c;
          end
        end
`ifdef CANVAS_CLEAR_EN
        // Sweep row-major, x fastest, one pixel per accepted write
        CLEAR: begin
          if (accept) begin
            if (bus.wr_x == X_MAX) begin
              bus.wr_x <= '0;
              if (bus.wr_y == Y_MAX) begin
                state        <= IDLE;
                bus.wr_valid <= 1'b0;
              end else begin
                bus.wr_y <= bus.wr_y + YW'(1);
              end
            end else begin
              bus.wr_x <= bus.wr_x + XW'(1);
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Directed bench for canvas_write_arbiter: reset, cursor wrap, held paint write,
// round-robin ties, clear sweep (or ignored i2c_clear) and reset during WRITE.
module tb_canvas_write_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [3:0] cur_x, cur_y;
  logic       busy;
  int         checks = 0;
  int         errors = 0;
  int         nwr = 0;
  int         n0;

  canvas_write_arbiter_if #(.XW(4), .YW(4)) bus ();

  canvas_write_arbiter #(.W(16), .H(16), .XW(4), .YW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .bus   (bus),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.wr_valid && bus.wr_ready) nwr <= nwr + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise then drop button bits; cursor/pend updated at the 3rd edge
  task automatic pulse(input logic [4:0] m);
    btn[4:0] = m;
    tick();
    btn[4:0] = 5'b0;
    tick();
    tick();
  endtask

  // Paint at cursor (1,1) rgb 3 and an I2C write pending on the same edge
  task automatic tie(input logic [3:0] ix, input logic [3:0] iy, input logic [2:0] ir);
    btn[4] = 1'b1;
    tick();
    btn[4] = 1'b0;
    tick();
    bus.i2c_valid = 1'b1;
    bus.i2c_x = ix;
    bus.i2c_y = iy;
    bus.i2c_rgb = ir;
    bus.i2c_clear = 1'b0;
    tick();
    bus.i2c_valid = 1'b0;
    chk("tie_i2c_ready_low", 32'(bus.i2c_ready), 0);
    tick();
    chk("tie_first_btn", 32'({bus.wr_valid, bus.wr_x, bus.wr_y, bus.wr_rgb}),
        32'({1'b1, 4'd1, 4'd1, 3'd3}));
    tick();
    chk("tie_bubble", 32'({bus.wr_valid, bus.i2c_ready}), 0);
    tick();
    chk("tie_second_i2c", 32'({bus.wr_valid, bus.wr_x, bus.wr_y, bus.wr_rgb}),
        32'({1'b1, ix, iy, ir}));
    tick();
    chk("tie_done", 32'({bus.wr_valid, busy, bus.i2c_ready}), 32'(3'b001));
  endtask

  initial begin
    rst = 1'b1;
    btn = 8'h00;
    bus.i2c_valid = 1'b0;
    bus.i2c_x = 4'd0;
    bus.i2c_y = 4'd0;
    bus.i2c_rgb = 3'd0;
    bus.i2c_clear = 1'b0;
    bus.wr_ready = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_wr_valid", 32'(bus.wr_valid), 0);
    chk("rst_wr_xyrgb", 32'({bus.wr_x, bus.wr_y, bus.wr_rgb}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cursor", 32'({cur_x, cur_y}), 0);
    chk("rst_i2c_ready", 32'(bus.i2c_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_i2c_ready", 32'(bus.i2c_ready), 1);

    // Cursor wrap and cancellation
    btn[2] = 1'b1;
    tick();
    btn[2] = 1'b0;
    tick();
    chk("left_before_3rd_edge", 32'(cur_x), 0);
    tick();
    chk("left_wrap", 32'(cur_x), 15);
    pulse(5'b00001);
    chk("up_wrap", 32'(cur_y), 15);
    pulse(5'b00011);
    chk("up_down_cancel", 32'({cur_x, cur_y}), 32'({4'd15, 4'd15}));
    repeat (4) pulse(5'b01010);
    repeat (2) pulse(5'b00010);
    chk("cursor_3_5", 32'({cur_x, cur_y}), 32'({4'd3, 4'd5}));

    // Paint held against wr_ready low
    btn[7:5] = 3'b101;
    tick();
    pulse(5'b10000);
    tick();
    chk("paint_valid", 32'({bus.wr_valid, busy}), 32'(2'b11));
    chk("paint_payload", 32'({bus.wr_x, bus.wr_y, bus.wr_rgb}), 32'({4'd3, 4'd5, 3'd5}));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("paint_hold", 32'({bus.wr_valid, bus.wr_x, bus.wr_y, bus.wr_rgb}),
          32'({1'b1, 4'd3, 4'd5, 3'd5}));
    end
    bus.wr_ready = 1'b1;
    tick();
    chk("paint_accepted", 32'({bus.wr_valid, busy}), 0);
    chk("paint_write_count", 32'(nwr), 1);

    // Round-robin ties from a fresh reset
    rst = 1'b1;
    btn = 8'h60;
    tick();
    tick();
    rst = 1'b0;
    pulse(5'b01010);
    chk("cursor_1_1", 32'({cur_x, cur_y}), 32'({4'd1, 4'd1}));
    tie(4'd7, 4'd9, 3'd2);
    tie(4'd10, 4'd12, 3'd6);
    chk("tie_write_count", 32'(nwr), 5);

`ifdef CANVAS_CLEAR_EN
    // Clear sweep with a paint issued mid-sweep
    bus.i2c_valid = 1'b1;
    bus.i2c_x = 4'd5;
    bus.i2c_y = 4'd5;
    bus.i2c_rgb = 3'd0;
    bus.i2c_clear = 1'b1;
    tick();
    bus.i2c_valid = 1'b0;
    bus.i2c_clear = 1'b0;
    chk("clr_i2c_ready_low", 32'(bus.i2c_ready), 0);
    tick();
    for (int k = 0; k < 256; k++) begin
      logic [3:0] xk, yk;
      xk = 4'(k % 16);
      yk = 4'(k / 16);
      chk("clr_sweep", 32'({bus.wr_valid, busy, bus.i2c_ready, bus.wr_x, bus.wr_y, bus.wr_rgb}),
          32'({1'b1, 1'b1, 1'b0, xk, yk, 3'd0}));
      if (k == 40) btn[4] = 1'b1;
      if (k == 41) btn[4] = 1'b0;
      tick();
    end
    chk("clr_end", 32'({bus.wr_valid, busy, bus.i2c_ready}), 32'(3'b001));
    tick();
    chk("clr_then_paint", 32'({bus.wr_valid, bus.wr_x, bus.wr_y, bus.wr_rgb}),
        32'({1'b1, 4'd1, 4'd1, 3'd3}));
    tick();
    chk("clr_paint_done", 32'({bus.wr_valid, busy}), 0);
    chk("clr_write_count", 32'(nwr), 262);
`else
    // i2c_clear is ignored: a single write to (x,y)
    bus.i2c_valid = 1'b1;
    bus.i2c_x = 4'd2;
    bus.i2c_y = 4'd3;
    bus.i2c_rgb = 3'd4;
    bus.i2c_clear = 1'b1;
    tick();
    bus.i2c_valid = 1'b0;
    bus.i2c_clear = 1'b0;
    tick();
    chk("noclr_single_write", 32'({bus.wr_valid, bus.wr_x, bus.wr_y, bus.wr_rgb}),
        32'({1'b1, 4'd2, 4'd3, 3'd4}));
    tick();
    chk("noclr_done", 32'({bus.wr_valid, busy, bus.i2c_ready}), 32'(3'b001));
    tick();
    chk("noclr_no_more", 32'(bus.wr_valid), 0);
    chk("noclr_write_count", 32'(nwr), 6);
`endif

    // Reset while stalled in WRITE
    bus.wr_ready = 1'b0;
    pulse(5'b10000);
    tick();
    chk("stall_valid", 32'({bus.wr_valid, busy}), 32'(2'b11));
    rst = 1'b1;
    tick();
    chk("midrst_idle", 32'({bus.wr_valid, busy}), 0);
    rst = 1'b0;
    n0 = nwr;
    bus.wr_ready = 1'b1;
    repeat (6) tick();
    chk("midrst_no_valid", 32'({bus.wr_valid, busy}), 0);
    chk("midrst_no_write", 32'(nwr), 32'(n0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
